// File: rtl/queue_pkg.sv
// Shared types and sizing for the byte queue.
package queue_pkg;

    localparam int QUEUE_DATA_W = 8;
    localparam int QUEUE_DEPTH  = 8;
    localparam int QUEUE_PTR_W  = $clog2(QUEUE_DEPTH);

    typedef logic [QUEUE_DATA_W-1:0] queue_data_t;
    typedef logic [QUEUE_PTR_W-1:0]  queue_ptr_t;

endpackage

// File: rtl/byte_queue.sv
// 8-deep x 8-bit synchronous FIFO with registered pop data and occupancy.
// Optional sticky overflow/underflow flags when QUEUE_ERR_FLAGS_EN is defined.
module byte_queue
    import queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int DEPTH  = QUEUE_DEPTH
) (
    input  logic                        clk_10khz,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        enqueue_in,
    input  logic                        dequeue_in,
    output logic [$clog2(DEPTH):0]      len_out,
    output logic [DATA_W-1:0]           data_out
`ifdef QUEUE_ERR_FLAGS_EN
    ,
    output logic                        overflow_out,
    output logic                        underflow_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [LEN_W-1:0]  count_reg;
    logic [LEN_W-1:0]  count_next;
    logic [DATA_W-1:0] data_out_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_reg == LEN_W'(DEPTH));
    assign empty = (count_reg == '0);
    // A pop frees the slot, so a push into a full queue is allowed alongside it.
    assign push  = enqueue_in & (~full | pop);
    assign pop   = dequeue_in & ~empty;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + LEN_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - LEN_W'(1);
        end
    end

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk_10khz) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                data_out_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    assign len_out  = count_reg;
    assign data_out = data_out_reg;

`ifdef QUEUE_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (enqueue_in && !push) begin
                overflow_reg <= 1'b1;
            end
            if (dequeue_in && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow_out  = overflow_reg;
    assign underflow_out = underflow_reg;
`endif

endmodule

// File: tb/tb_byte_queue.sv
// Directed, table-driven bench for byte_queue; checks len_out and data_out each cycle.
`timescale 1us/1ns
module tb_byte_queue;

    logic       clk_10khz;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       dequeue_in;
    logic [3:0] len_out;
    logic [7:0] data_out;
`ifdef QUEUE_ERR_FLAGS_EN
    logic       overflow_out;
    logic       underflow_out;
`endif

    byte_queue dut (
        .clk_10khz  (clk_10khz),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .len_out    (len_out),
        .data_out   (data_out)
`ifdef QUEUE_ERR_FLAGS_EN
        ,
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
`endif
    );

    initial clk_10khz = 1'b0;
    always #50 clk_10khz = ~clk_10khz;

    typedef struct {
        logic       enq;
        logic       deq;
        logic [7:0] din;
        logic [3:0] len;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   passes;

    task automatic add(input logic enq, input logic deq, input logic [7:0] din,
                       input logic [3:0] len, input logic [7:0] dout);
        vec_t v;
        v.enq = enq; v.deq = deq; v.din = din; v.len = len; v.dout = dout;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then sample just after it.
    task automatic step(input logic rst, input logic enq, input logic deq, input logic [7:0] din);
        reset      = rst;
        enqueue_in = enq;
        dequeue_in = deq;
        data_in    = din;
        @(posedge clk_10khz);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] len, input logic [7:0] dout);
        check({tag, " len"},  {4'h0, len_out}, {4'h0, len});
        check({tag, " dout"}, data_out, dout);
        $display("%s: enq=%0b deq=%0b din=%02h -> len=%0d dout=%02h", tag,
                 enqueue_in, dequeue_in, data_in, len_out, data_out);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset = 1'b1; enqueue_in = 1'b0; dequeue_in = 1'b0; data_in = 8'h00;

        // 1: reset
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_state("reset", 4'd0, 8'h00);
`ifdef QUEUE_ERR_FLAGS_EN
        check("reset ovf", {7'h0, overflow_out}, 8'h00);
        check("reset udf", {7'h0, underflow_out}, 8'h00);
`endif

        // 2: fill
        add(1, 0, 8'hA5, 1, 8'h00);
        for (int i = 2; i <= 8; i++) add(1, 0, 8'(i), 4'(i), 8'h00);
        // 3: overflow dropped
        add(1, 0, 8'hFF, 8, 8'h00);
        // 4: single pop
        add(0, 1, 8'h00, 7, 8'hA5);
        // 5: simultaneous push+pop, then drain
        add(1, 1, 8'h77, 7, 8'h02);
        for (int i = 3; i <= 8; i++) add(0, 1, 8'h00, 4'(9 - i), 8'(i));
        add(0, 1, 8'h00, 0, 8'h77);
        // 6: underflow holds last value
        for (int i = 0; i < 10; i++) add(0, 1, 8'h00, 0, 8'h77);
        // push+pop on empty: push only
        add(1, 1, 8'h3C, 1, 8'h77);
        add(0, 1, 8'h00, 0, 8'h3C);
        add(1, 0, 8'h11, 1, 8'h3C);
        add(1, 0, 8'h22, 2, 8'h3C);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].enq, vecs[i].deq, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].len, vecs[i].dout);
`ifdef QUEUE_ERR_FLAGS_EN
            if (i == 8) check("ovf set", {7'h0, overflow_out}, 8'h01);
            if (i == 7) check("ovf clear", {7'h0, overflow_out}, 8'h00);
            if (i == 17) check("udf clear", {7'h0, underflow_out}, 8'h00);
            if (i == 18) check("udf set", {7'h0, underflow_out}, 8'h01);
`endif
        end

        // Reset mid-stream with enqueue asserted
        step(1'b1, 1'b1, 1'b0, 8'h99);
        check_state("rst_mid", 4'd0, 8'h00);
`ifdef QUEUE_ERR_FLAGS_EN
        check("rst ovf", {7'h0, overflow_out}, 8'h00);
        check("rst udf", {7'h0, underflow_out}, 8'h00);
`endif
        // After reset, pointers restart: push two, pop two in order
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        check_state("post_push1", 4'd1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hC3);
        check_state("post_push2", 4'd2, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_pop1", 4'd1, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_pop2", 4'd0, 8'hC3);

        // Full queue with simultaneous push+pop keeps len at 8 and ordering intact
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        check_state("refill", 4'd8, 8'hC3);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        check_state("full_pp", 4'd8, 8'h40);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("full_drain%0d", i), 4'(8 - i), 8'(8'h40 + i));
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("full_drain_last", 4'd0, 8'hEE);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
